// File: rtl/bcd_scan_pkg.sv
// Shared constants and helpers for the BCD scan counter.
// Included by the decade cell and the top-level counter.
package bcd_scan_pkg;

   localparam int          NUM_DIGITS    = 8;
   localparam int          BCD_W         = 4;
   localparam logic [3:0]  BCD_MAX       = 4'd9;
   localparam int          SCAN_W        = 3;
   localparam logic [7:0]  DIGIT_MSB_SEL = 8'b1000_0000;

   // Clamp a nibble into the legal BCD range.
   function automatic logic [BCD_W-1:0] bcd_sat(
      input logic [BCD_W-1:0] v
   );
      return (v > BCD_MAX) ? BCD_MAX : v;
   endfunction

endpackage

// File: rtl/bcd_scan_counter_decade.sv
// One combinational BCD decade: step by one when cin is set.
// Ports: val/up/cin in; nxt (next value), cout (carry/borrow out).
module bcd_decade
   import bcd_scan_pkg::*;
(
   input  logic [BCD_W-1:0] val,
   input  logic             up,
   input  logic             cin,
   output logic [BCD_W-1:0] nxt,
   output logic             cout
);

   always_comb begin
      nxt  = val;
      cout = 1'b0;
      if (cin) begin
         if (up) begin
            if (val >= BCD_MAX) begin
               nxt  = '0;
               cout = 1'b1;
            end else begin
               nxt = val + 1'b1;
            end
         end else begin
            if (val == '0) begin
               nxt  = BCD_MAX;
               cout = 1'b1;
            end else begin
               nxt = val - 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/bcd_scan_counter.sv
// Eight-digit BCD up/down counter with a one-hot digit scanner.
// Ports: clk_1hz, rstb, run, up, clr, load, load_val in; count, digit, num, wrap out.
module bcd_scan_counter
   import bcd_scan_pkg::*;
#(
   parameter int NUM_DIGITS = 8
) (
   input  logic                        clk_1hz,
   input  logic                        rstb,
   input  logic                        run,
   input  logic                        up,
   input  logic                        clr,
   input  logic                        load,
   input  logic [NUM_DIGITS*BCD_W-1:0] load_val,
   output logic [NUM_DIGITS*BCD_W-1:0] count,
   output logic [NUM_DIGITS-1:0]       digit,
   output logic [BCD_W-1:0]            num,
   output logic                        wrap
);

   localparam int CW = NUM_DIGITS * BCD_W;

   logic [SCAN_W-1:0] scan_idx;
   logic [NUM_DIGITS:0] carry;
   logic [CW-1:0] cnt_step;
   logic [CW-1:0] load_sat;

   // Ripple chain: LSD takes run as its carry-in.
   assign carry[0] = run;

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
      bcd_decade u_dec (
         .val  (count[g*BCD_W +: BCD_W]),
         .up   (up),
         .cin  (carry[g]),
         .nxt  (cnt_step[g*BCD_W +: BCD_W]),
         .cout (carry[g+1])
      );
   end

   always_comb begin
      load_sat = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         load_sat[i*BCD_W +: BCD_W] =
            bcd_sat(load_val[i*BCD_W +: BCD_W]);
      end
   end

   always_ff @(posedge clk_1hz or negedge rstb) begin
      if (!rstb) begin
         count    <= '0;
         scan_idx <= '0;
         wrap     <= 1'b0;
      end else begin
         scan_idx <= scan_idx + 1'b1;
         if (clr) begin
            count <= '0;
            wrap  <= 1'b0;
         end else if (load) begin
            count <= load_sat;
            wrap  <= 1'b0;
         end else if (run) begin
            count <= cnt_step;
            wrap  <= carry[NUM_DIGITS];
         end else begin
            wrap  <= 1'b0;
         end
      end
   end

   assign digit = DIGIT_MSB_SEL >> scan_idx;

   // Scan index 0 is the MSD, so walk nibbles from the top.
   always_comb begin
      num = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (scan_idx == SCAN_W'(i)) begin
            num = count[(NUM_DIGITS-1-i)*BCD_W +: BCD_W];
         end
      end
   end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Scoreboard bench for bcd_scan_counter.
// Directed steps push expectations; a monitor pops and compares.
`timescale 1ns/1ps
module tb_bcd_scan_counter;

   logic        clk_1hz = 1'b0;
   logic        rstb = 1'b0;
   logic        run = 1'b0;
   logic        up = 1'b0;
   logic        clr = 1'b0;
   logic        load = 1'b0;
   logic [31:0] load_val = '0;
   logic [31:0] count;
   logic [7:0]  digit;
   logic [3:0]  num;
   logic        wrap;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] c;
      logic        w;
   } exp_t;

   exp_t q[$];
   logic [2:0] scan_m = '0;

   bcd_scan_counter #(.NUM_DIGITS(8)) dut (
      .clk_1hz  (clk_1hz),
      .rstb     (rstb),
      .run      (run),
      .up       (up),
      .clr      (clr),
      .load     (load),
      .load_val (load_val),
      .count    (count),
      .digit    (digit),
      .num      (num),
      .wrap     (wrap)
   );

   always #5 clk_1hz = ~clk_1hz;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // Monitor: scan position advances every edge out of reset.
   always @(posedge clk_1hz) begin
      exp_t e;
      logic [31:0] sh;
      #1;
      if (!rstb) begin
         scan_m = '0;
      end else begin
         scan_m = scan_m + 3'd1;
         if (q.size() > 0) begin
            e  = q.pop_front();
            sh = e.c >> (28 - 4 * int'(scan_m));
            chk("count", count, e.c);
            chk("wrap", {31'b0, wrap}, {31'b0, e.w});
            chk("digit", {24'b0, digit}, {24'b0, 8'h80 >> scan_m});
            chk("num", {28'b0, num}, {28'b0, sh[3:0]});
         end
      end
   end

   task automatic step(input logic c, input logic l, input logic r,
                       input logic u, input logic [31:0] lv,
                       input logic [31:0] ec, input logic ew);
      exp_t e;
      @(negedge clk_1hz);
      clr = c; load = l; run = r; up = u; load_val = lv;
      e.c = ec;
      e.w = ew;
      q.push_back(e);
   endtask

   task automatic drain();
      @(negedge clk_1hz);
      clr = 0; load = 0; run = 0;
      @(negedge clk_1hz);
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d required=0", q.size());
         q.delete();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "timeout");
   end

   initial begin
      #3;
      chk("rst_count", count, 32'h0);
      chk("rst_digit", {24'b0, digit}, 32'h80);
      chk("rst_num", {28'b0, num}, 32'h0);
      chk("rst_wrap", {31'b0, wrap}, 32'h0);
      @(negedge clk_1hz);
      rstb = 1'b1;

      // carry chain
      step(0, 1, 0, 0, 32'h00000099, 32'h00000099, 0);
      step(0, 0, 1, 1, 32'h0,        32'h00000100, 0);
      // up wrap
      step(0, 1, 0, 0, 32'h99999999, 32'h99999999, 0);
      step(0, 0, 1, 1, 32'h0,        32'h00000000, 1);
      step(0, 0, 1, 1, 32'h0,        32'h00000001, 0);
      // down wrap
      step(1, 0, 0, 0, 32'h0,        32'h00000000, 0);
      step(0, 0, 1, 0, 32'h0,        32'h99999999, 1);
      step(0, 0, 0, 0, 32'h0,        32'h99999999, 0);
      // priority and saturation
      step(1, 1, 1, 1, 32'h11111111, 32'h00000000, 0);
      step(0, 1, 1, 1, 32'hF0A0000B, 32'h90900009, 0);
      // borrow ripple
      step(0, 1, 0, 0, 32'h00001000, 32'h00001000, 0);
      step(0, 0, 1, 0, 32'h0,        32'h00000999, 0);
      step(0, 0, 1, 1, 32'h0,        32'h00001000, 0);
      // scan: nine hold edges walk every digit and wrap
      step(0, 1, 0, 0, 32'h12345678, 32'h12345678, 0);
      for (int i = 0; i < 9; i++) begin
         step(0, 0, 0, 1, 32'h0, 32'h12345678, 0);
      end
      drain();

      // reset mid-run, no clock edge needed
      step(1, 0, 0, 0, 32'h0, 32'h00000000, 0);
      step(0, 0, 1, 1, 32'h0, 32'h00000001, 0);
      step(0, 0, 1, 1, 32'h0, 32'h00000002, 0);
      @(negedge clk_1hz);
      run = 1; up = 1;
      #1;
      chk("pre_rst_count", count, 32'h00000002);
      #1;
      rstb = 1'b0;
      #1;
      chk("mid_rst_count", count, 32'h0);
      chk("mid_rst_digit", {24'b0, digit}, 32'h80);
      chk("mid_rst_num", {28'b0, num}, 32'h0);
      chk("mid_rst_wrap", {31'b0, wrap}, 32'h0);
      @(negedge clk_1hz);
      run = 0;
      @(negedge clk_1hz);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
